// File: rtl/mc_ifetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : mc_ifetch_responder
// Brief    : Fetches one aligned instruction block byte-by-byte from the RAM
//            port on an ICache request and returns it as a one-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ifetch_responder #(
    parameter int BLOCK_WIDTH = 2,
    parameter int BLOCK_SIZE  = 1 << BLOCK_WIDTH
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      icache_query_en,
    input  logic [31:0]               icache_query_addr,
    output logic                      icache_data_en,
    output logic [32*BLOCK_SIZE-1:0]  icache_data,
    output logic                      busy,
    output logic                      mem_req,
    input  logic                      mem_grant,
    output logic [31:0]               mem_a,
    output logic                      mem_wr,
    input  logic [7:0]                mem_din
);

    localparam int NBYTE = 4 * BLOCK_SIZE;
    localparam int OFF_W = BLOCK_WIDTH + 2;
    localparam int PTR_W = OFF_W + 1;
    localparam logic [PTR_W-1:0] NBYTE_P = PTR_W'(NBYTE);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(NBYTE - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_GRANT = 2'd1,
        S_READ       = 2'd2
    } state_t;

    state_t             r_state,     w_state;
    logic [31:0]        r_base,      w_base;
    logic [PTR_W-1:0]   r_issue_ptr, w_issue_ptr;
    logic [PTR_W-1:0]   r_cap_cnt,   w_cap_cnt;
    logic               r_inflight,  w_inflight;
    logic               r_data_en,   w_data_en;
    logic [8*NBYTE-1:0] r_data,      w_data;
    logic               w_unused_addr_bits;

    // Offset bits within the block are discarded when the base is latched.
    assign w_unused_addr_bits = ^icache_query_addr[OFF_W-1:0];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_issue_ptr <= '0;
            r_cap_cnt   <= '0;
            r_inflight  <= 1'b0;
            r_data_en   <= 1'b0;
            r_data      <= '0;
        end else begin
            r_state     <= w_state;
            r_base      <= w_base;
            r_issue_ptr <= w_issue_ptr;
            r_cap_cnt   <= w_cap_cnt;
            r_inflight  <= w_inflight;
            r_data_en   <= w_data_en;
            r_data      <= w_data;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_base      = r_base;
        w_issue_ptr = r_issue_ptr;
        w_cap_cnt   = r_cap_cnt;
        w_inflight  = r_inflight;
        w_data_en   = 1'b0;
        w_data      = r_data;
        case (r_state)
            S_IDLE: begin
                if (rdy_in && icache_query_en) begin
                    w_base  = {icache_query_addr[31:OFF_W], {OFF_W{1'b0}}};
                    w_state = S_WAIT_GRANT;
                end
            end
            S_WAIT_GRANT: begin
                if (rdy_in && mem_grant) begin
                    w_state     = S_READ;
                    w_issue_ptr = '0;
                    w_cap_cnt   = '0;
                    w_inflight  = 1'b0;
                end
            end
            S_READ: begin
                if (rdy_in) begin
                    if (r_issue_ptr < NBYTE_P) begin
                        w_issue_ptr = r_issue_ptr + 1'b1;
                        w_inflight  = 1'b1;
                    end else begin
                        w_inflight  = 1'b0;
                    end
                    // mem_din holds the byte addressed one edge earlier.
                    if (r_inflight) begin
                        for (int k = 0; k < NBYTE; k++) begin
                            if (r_cap_cnt == PTR_W'(k)) begin
                                w_data[8*k +: 8] = mem_din;
                            end
                        end
                        w_cap_cnt = r_cap_cnt + 1'b1;
                        if (r_cap_cnt == LAST_P) begin
                            w_data_en = 1'b1;
                            w_state   = S_IDLE;
                        end
                    end
                end else begin
                    // A pause drops the byte in flight; re-issue from the first uncaptured one.
                    w_issue_ptr = r_cap_cnt;
                    w_inflight  = 1'b0;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign icache_data_en = r_data_en;
    assign icache_data    = r_data;
    assign busy           = (r_state != S_IDLE);
    assign mem_req        = busy;
    assign mem_wr         = 1'b0;
    assign mem_a          = (r_state == S_READ && r_issue_ptr < NBYTE_P)
                          ? (r_base | {{(32-PTR_W){1'b0}}, r_issue_ptr})
                          : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mc_ifetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ifetch_responder
// Brief    : Self-checking bench for mc_ifetch_responder against a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ifetch_responder;

    localparam int NBYTE = 16;

    logic         clk_in;
    logic         rst_in;
    logic         rdy_in;
    logic         icache_query_en;
    logic [31:0]  icache_query_addr;
    logic         icache_data_en;
    logic [127:0] icache_data;
    logic         busy;
    logic         mem_req;
    logic         mem_grant;
    logic [31:0]  mem_a;
    logic         mem_wr;
    logic [7:0]   mem_din;

    logic [7:0]   ram [0:65535];
    int           cyc;
    int           n_assert;
    int           n_fail;

    mc_ifetch_responder #(.BLOCK_WIDTH(2)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .icache_query_en   (icache_query_en),
        .icache_query_addr (icache_query_addr),
        .icache_data_en    (icache_data_en),
        .icache_data       (icache_data),
        .busy              (busy),
        .mem_req           (mem_req),
        .mem_grant         (mem_grant),
        .mem_a             (mem_a),
        .mem_wr            (mem_wr),
        .mem_din           (mem_din)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // RAM returns the byte addressed at the previous rising edge.
    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[15:0]];
        cyc     <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One fetch; pause edges are counted relative to the granting edge.
    task automatic do_fetch(input logic [31:0] addr, input int gdelay,
                            input int pstart, input int plen, input bit stray);
        logic [31:0]  base;
        logic [127:0] exp;
        int e0, g, lat, r, pulses;
        base = {addr[31:4], 4'h0};
        for (int k = 0; k < NBYTE; k++) exp[8*k +: 8] = ram[base[15:0] + 16'(k)];
        icache_query_en   = 1'b1;
        icache_query_addr = addr;
        mem_grant         = (gdelay == 0);
        @(posedge clk_in); @(negedge clk_in);
        icache_query_en = 1'b0;
        e0 = cyc;
        chk("accept_busy", busy, 1'b1);
        chk("accept_mem_req", mem_req, 1'b1);
        chk("wait_mem_a", mem_a, 32'h0);
        chk("pulse_cleared", icache_data_en, 1'b0);
        for (int i = 1; i <= gdelay; i++) begin
            @(posedge clk_in); @(negedge clk_in);
            chk("grant_wait_req", mem_req, 1'b1);
            chk("grant_wait_mem_a", mem_a, 32'h0);
            if (i == gdelay) mem_grant = 1'b1;
        end
        g   = e0 + gdelay + 1;
        lat = NBYTE + 2 + gdelay + ((plen > 0) ? plen + 1 : 0);
        pulses = 0;
        while (cyc < e0 + lat && cyc < e0 + 200) begin
            r = cyc + 1 - g;
            rdy_in = !(plen > 0 && r >= pstart && r < pstart + plen);
            icache_query_en = stray && (r == 3);
            icache_query_addr = stray ? $urandom : addr;
            @(posedge clk_in); @(negedge clk_in);
            r = cyc - g;
            if (icache_data_en) pulses++;
            chk("data_en_timing", icache_data_en, (cyc == e0 + lat));
            if (plen == 0 && r >= 0)
                chk("mem_a_seq", mem_a, (r < NBYTE) ? (base + 32'(r)) : 32'h0);
        end
        rdy_in = 1'b1;
        icache_query_en = 1'b0;
        chk("single_pulse", 32'(pulses), 32'd1);
        chk("block_data", icache_data, exp);
        chk("done_idle", busy, 1'b0);
        chk("done_mem_req", mem_req, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_en"}, icache_data_en, 1'b0);
        chk({tag, "_data"}, icache_data, 128'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_mem_req"}, mem_req, 1'b0);
        chk({tag, "_mem_a"}, mem_a, 32'h0);
        chk({tag, "_mem_wr"}, mem_wr, 1'b0);
    endtask

    initial begin
        int e0, pulses;
        logic [127:0] held;
        n_assert = 0; n_fail = 0; cyc = 0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        for (int k = 0; k < NBYTE; k++) ram[16'h1000 + 16'(k)] = 8'(k);
        rst_in = 1'b1; rdy_in = 1'b1; icache_query_en = 1'b0;
        icache_query_addr = 32'h0; mem_grant = 1'b1;
        @(negedge clk_in); @(negedge clk_in);
        chk_reset_outputs("reset");
        rst_in = 1'b0;
        @(negedge clk_in);

        // Paused in IDLE: query must not be taken.
        rdy_in = 1'b0; icache_query_en = 1'b1; icache_query_addr = 32'h2000;
        repeat (2) @(negedge clk_in);
        chk("paused_idle_busy", busy, 1'b0);
        rdy_in = 1'b1; icache_query_en = 1'b0;
        @(negedge clk_in);

        // Nominal block, then the exact little-endian words.
        do_fetch(32'h0000_100C, 0, 0, 0, 1'b0);
        chk("words_0x1000", icache_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        @(negedge clk_in);
        do_fetch(32'h0000_1000, 5, 0, 0, 1'b0);
        chk("words_grant_delay", icache_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        @(negedge clk_in);
        do_fetch(32'h0000_1004, 0, 8, 3, 1'b0);
        chk("words_paused", icache_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

        // Stray query while busy, then back-to-back query in the pulse cycle.
        @(negedge clk_in);
        do_fetch(32'h0000_100C, 0, 0, 0, 1'b1);
        do_fetch(32'h0000_FFF0, 0, 0, 0, 1'b0);

        // Idle hold keeps the block stable.
        held = icache_data;
        repeat (3) @(negedge clk_in);
        chk("data_stable_idle", icache_data, held);

        // Reset in mid-fetch aborts it asynchronously.
        icache_query_en = 1'b1; icache_query_addr = 32'h0000_1000; mem_grant = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        icache_query_en = 1'b0;
        e0 = cyc;
        while (cyc < e0 + 10) @(negedge clk_in);
        chk("pre_reset_mem_req", mem_req, 1'b1);
        #2 rst_in = 1'b1;
        #1 chk_reset_outputs("async_reset");
        @(negedge clk_in);
        rst_in = 1'b0;
        pulses = 0;
        repeat (25) begin
            @(negedge clk_in);
            if (icache_data_en) pulses++;
        end
        chk("aborted_no_pulse", 32'(pulses), 32'd0);
        do_fetch(32'h0000_1008, 0, 0, 0, 1'b0);
        chk("post_reset_words", icache_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

        // Randomized fetches: address, grant delay, optional mid-transfer pause.
        for (int t = 0; t < 12; t++) begin
            int gd, ps, pl;
            gd = $urandom_range(0, 4);
            pl = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
            ps = $urandom_range(2, 17);
            if ($urandom_range(0, 1) == 1) @(negedge clk_in);
            do_fetch($urandom, gd, ps, pl, 1'(($urandom_range(0, 1))));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
